// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory-access stage: one-hot bit positions, FSM
// encodings, the captured-instruction bundle and its reset values.
package mem_stage_pkg;

  localparam int DW_C = 32;

  // Bit positions inside exe_sel_wbdata_in
  localparam int SEL_ALU   = 0;
  localparam int SEL_LOAD  = 1;
  localparam int SEL_MERGE = 2;
  localparam int SEL_LINK  = 3;

  // Bit positions inside exe_lubhw_con_in
  localparam int LD_LB  = 0;
  localparam int LD_LBU = 1;
  localparam int LD_LH  = 2;
  localparam int LD_LHU = 3;
  localparam int LD_LW  = 4;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [DW_C-1:0] INI_ALURES     = '0;
  localparam logic [1:0]      INI_ADDR_LO    = '0;
  localparam logic [3:0]      INI_SEL_WBDATA = '0;
  localparam logic [4:0]      INI_LUBHW_CON  = '0;
  localparam logic [7:0]      INI_ONEHOT     = '0;
  localparam logic [DW_C-1:0] INI_RT_DATA    = '0;
  localparam logic [DW_C-1:0] INI_PC         = '0;
  localparam logic [DW_C-1:0] INI_NNPC       = '0;
  localparam logic [4:0]      INI_WNUM       = '0;
  localparam logic [2:0]      INI_WRITE_TYPE = '0;
  localparam logic [DW_C-1:0] INI_RDATA      = '0;
  localparam logic [1:0]      INI_STATE      = ST_EMPTY;

  typedef struct packed {
    logic [DW_C-1:0] alures;
    logic [1:0]      addr_lo;
    logic [3:0]      sel_wbdata;
    logic [4:0]      lubhw_con;
    logic [7:0]      onehot;
    logic [DW_C-1:0] rt_data;
    logic [DW_C-1:0] pc;
    logic [DW_C-1:0] nnpc;
    logic [4:0]      wnum;
    logic [2:0]      write_type;
  } exe_bundle_t;

  localparam exe_bundle_t INI_BUNDLE = '{
    alures:     INI_ALURES,
    addr_lo:    INI_ADDR_LO,
    sel_wbdata: INI_SEL_WBDATA,
    lubhw_con:  INI_LUBHW_CON,
    onehot:     INI_ONEHOT,
    rt_data:    INI_RT_DATA,
    pc:         INI_PC,
    nnpc:       INI_NNPC,
    wnum:       INI_WNUM,
    write_type: INI_WRITE_TYPE
  };

  function automatic logic is_load(input logic [3:0] sel_wbdata);
    return sel_wbdata[SEL_LOAD] | sel_wbdata[SEL_MERGE];
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load formatter: byte/halfword extraction with sign/zero
// extension, plus LWL/LWR merging of the memory word into the old rt value.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [DW_C-1:0] rdata_i,
  input  logic [1:0]      addr_i,
  input  logic [4:0]      lubhw_con_i,
  input  logic [7:0]      onehot_i,
  input  logic [DW_C-1:0] rt_i,
  output logic [DW_C-1:0] aligned_o,
  output logic [DW_C-1:0] merged_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    byte_v = rdata_i[7:0];
    case (addr_i)
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      2'd3:    byte_v = rdata_i[31:24];
      default: byte_v = rdata_i[7:0];
    endcase
  end

  assign half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  assign aligned_o = ({DW_C{lubhw_con_i[LD_LB]}}  & {{24{byte_v[7]}}, byte_v})
                   | ({DW_C{lubhw_con_i[LD_LBU]}} & {24'd0, byte_v})
                   | ({DW_C{lubhw_con_i[LD_LH]}}  & {{16{half_v[15]}}, half_v})
                   | ({DW_C{lubhw_con_i[LD_LHU]}} & {16'd0, half_v})
                   | ({DW_C{lubhw_con_i[LD_LW]}}  & rdata_i);

  // onehot[3:0] = LWL at offset 0..3, onehot[7:4] = LWR at offset 0..3
  assign merged_o = ({DW_C{onehot_i[0]}} & {rdata_i[7:0],  rt_i[23:0]})
                  | ({DW_C{onehot_i[1]}} & {rdata_i[15:0], rt_i[15:0]})
                  | ({DW_C{onehot_i[2]}} & {rdata_i[23:0], rt_i[7:0]})
                  | ({DW_C{onehot_i[3]}} & rdata_i)
                  | ({DW_C{onehot_i[4]}} & rdata_i)
                  | ({DW_C{onehot_i[5]}} & {rt_i[31:24], rdata_i[31:8]})
                  | ({DW_C{onehot_i[6]}} & {rt_i[31:16], rdata_i[31:16]})
                  | ({DW_C{onehot_i[7]}} & {rt_i[31:8],  rdata_i[31:24]});

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds execute results, waits for data-RAM
// read responses and forms the write-back value. MEM_FWD_EN enables the bypass ports.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_allowin_in,
  output logic          mem_allowin_out,
  input  logic          exe_valid_in,
  output logic          mem_valid_out,
  input  logic [DW-1:0] exe_alures_in,
  input  logic [DW-1:0] exe_dm_addr_in,
  input  logic [3:0]    exe_sel_wbdata_in,
  input  logic [4:0]    exe_lubhw_con_in,
  input  logic [7:0]    exe_onehot_in,
  input  logic [DW-1:0] exe_rt_data_in,
  input  logic [DW-1:0] exe_PC_in,
  input  logic [DW-1:0] exe_NNPC_in,
  input  logic [4:0]    exe_wnum_in,
  input  logic [2:0]    exe_write_type_in,
  input  logic [DW-1:0] dm_rdata_in,
  input  logic          dm_data_ok_in,
  output logic [DW-1:0] mem_wbdata_out,
  output logic [4:0]    mem_wnum_out,
  output logic [2:0]    mem_write_type_out,
  output logic [DW-1:0] mem_PC_out,
  output logic [DW-1:0] mem_NNPC_out,
  output logic          mem_fwd_valid_out,
  output logic [DW-1:0] mem_fwd_data_out
);

  logic [1:0]    state_q, state_d;
  exe_bundle_t   pipe_q, pipe_d, pipe_in;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          ready;
  logic          resp_now;
  logic          xfer_in;
  logic [1:0]    next_after_leave;
  logic [DW-1:0] src_rdata;
  logic [DW-1:0] aligned;
  logic [DW-1:0] merged;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^exe_dm_addr_in[DW-1:2];

  assign pipe_in = '{
    alures:     exe_alures_in,
    addr_lo:    exe_dm_addr_in[1:0],
    sel_wbdata: exe_sel_wbdata_in,
    lubhw_con:  exe_lubhw_con_in,
    onehot:     exe_onehot_in,
    rt_data:    exe_rt_data_in,
    pc:         exe_PC_in,
    nnpc:       exe_NNPC_in,
    wnum:       exe_wnum_in,
    write_type: exe_write_type_in
  };

  // A response only counts while a load is actually waiting for it.
  assign resp_now        = (state_q == ST_WAIT) && dm_data_ok_in;
  assign ready           = (state_q == ST_HOLD) || resp_now;
  assign mem_valid_out   = (state_q != ST_EMPTY) && ready;
  assign mem_allowin_out = (state_q == ST_EMPTY) || (ready && wb_allowin_in);
  assign xfer_in         = exe_valid_in && mem_allowin_out;

  always_comb begin
    next_after_leave = ST_EMPTY;
    if (xfer_in) begin
      next_after_leave = is_load(exe_sel_wbdata_in) ? ST_WAIT : ST_HOLD;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: state_d = next_after_leave;
      ST_WAIT: begin
        if (dm_data_ok_in) begin
          state_d = wb_allowin_in ? next_after_leave : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (wb_allowin_in) begin
          state_d = next_after_leave;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    pipe_d  = pipe_q;
    rdata_d = rdata_q;
    if (xfer_in) begin
      pipe_d = pipe_in;
    end
    if (resp_now) begin
      rdata_d = dm_rdata_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the captured read word is reset like every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INI_STATE;
      pipe_q  <= INI_BUNDLE;
      rdata_q <= INI_RDATA;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
      rdata_q <= rdata_d;
    end
  end

  // Same-cycle response bypass avoids a bubble when WB accepts immediately.
  assign src_rdata = resp_now ? dm_rdata_in : rdata_q;

  mem_stage_load_align u_load_align (
    .rdata_i     (src_rdata),
    .addr_i      (pipe_q.addr_lo),
    .lubhw_con_i (pipe_q.lubhw_con),
    .onehot_i    (pipe_q.onehot),
    .rt_i        (pipe_q.rt_data),
    .aligned_o   (aligned),
    .merged_o    (merged)
  );

  assign mem_wbdata_out = ({DW{pipe_q.sel_wbdata[SEL_ALU]}}   & pipe_q.alures)
                        | ({DW{pipe_q.sel_wbdata[SEL_LOAD]}}  & aligned)
                        | ({DW{pipe_q.sel_wbdata[SEL_MERGE]}} & merged)
                        | ({DW{pipe_q.sel_wbdata[SEL_LINK]}}  & pipe_q.nnpc);

  assign mem_wnum_out       = {5{mem_valid_out}} & pipe_q.wnum;
  assign mem_write_type_out = {3{mem_valid_out}} & pipe_q.write_type;
  assign mem_PC_out         = pipe_q.pc;
  assign mem_NNPC_out       = pipe_q.nnpc;

`ifdef MEM_FWD_EN
  // Loads never bypass: their value is not an ALU/NNPC result, so the decoder stalls on them.
  assign mem_fwd_valid_out = (state_q != ST_EMPTY) && (pipe_q.write_type != 3'd0)
                             && !is_load(pipe_q.sel_wbdata);
  assign mem_fwd_data_out  = ({DW{pipe_q.sel_wbdata[SEL_ALU]}}  & pipe_q.alures)
                           | ({DW{pipe_q.sel_wbdata[SEL_LINK]}} & pipe_q.nnpc);
`else
  assign mem_fwd_valid_out = 1'b0;
  assign mem_fwd_data_out  = '0;
`endif

endmodule
